// File: rtl/scanner_receiver.sv
// scanner_receiver: receive end of the scanner serial link; oversamples clkIn/dataIn on clk and
// presents WIDTH-bit MSB-first words on a valid/ack handshake. Define SCANNER_RX_PARITY_EN for a trailing even-parity bit.
//
//  state | meaning
//  IDLE  | waiting for the first serial clock edge of a frame, ready=1
//  RECV  | collecting bits, timeout counter running, ready=1
//  FULL  | dataWord holds an unconsumed word, ready=0, edges ignored
//  ABORT | one-cycle frameErr pulse, partial frame discarded
module scanner_receiver #(
    parameter int WIDTH   = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clkIn,
    input  logic             dataIn,
    input  logic             ackIn,
    output logic             readyForTransferOut,
    output logic [WIDTH-1:0] dataWord,
    output logic             dataValid,
    output logic             frameErr,
    output logic [1:0]       ps
);

`ifdef SCANNER_RX_PARITY_EN
    localparam int PAR_BITS = 1;
`else
    localparam int PAR_BITS = 0;
`endif
    localparam int FRAME = WIDTH + PAR_BITS;
    localparam int CW    = $clog2(FRAME + 1);
    localparam int TW    = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RECV  = 2'b01,
        FULL  = 2'b10,
        ABORT = 2'b11
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic             clk_s1;
    logic             clk_s2;
    logic             clk_h;
    logic             dat_s1;
    logic             dat_s2;
    logic             clk_rise;
    logic             sbit;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sr_shift;
    logic [WIDTH-1:0] word_cand;
    logic [CW-1:0]    cnt;
    logic [CW-1:0]    cnt_inc;
    logic [TW-1:0]    tcnt;
    logic             last_bit;
    logic             parity_ok;
    logic             timed_out;

    // Data travels through the same two flops as the clock so the bit lines up with its edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            clk_s1 <= 1'b0;
            clk_s2 <= 1'b0;
            clk_h  <= 1'b0;
            dat_s1 <= 1'b0;
            dat_s2 <= 1'b0;
        end else begin
            clk_s1 <= clkIn;
            clk_s2 <= clk_s1;
            clk_h  <= clk_s2;
            dat_s1 <= dataIn;
            dat_s2 <= dat_s1;
        end
    end

    assign clk_rise  = clk_s2 & ~clk_h;
    assign sbit      = dat_s2;
    assign cnt_inc   = cnt + CW'(1);
    assign last_bit  = (cnt_inc == CW'(FRAME));
    assign timed_out = (tcnt == TW'(TIMEOUT - 1));

    generate
        if (WIDTH == 1) begin : g_shift1
            assign sr_shift = sbit;
        end else begin : g_shiftn
            assign sr_shift = {sr[WIDTH-2:0], sbit};
        end
    endgenerate

`ifdef SCANNER_RX_PARITY_EN
    // The final serial bit is parity, so the word is already complete in sr.
    assign parity_ok = ~(^sr ^ sbit);
    assign word_cand = sr;
`else
    logic unused_msb;
    assign parity_ok  = 1'b1;
    assign word_cand  = sr_shift;
    assign unused_msb = sr[WIDTH-1];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx            = state;
        readyForTransferOut = 1'b1;
        dataValid           = 1'b0;
        frameErr            = 1'b0;
        case (state)
            IDLE: begin
                if (clk_rise) begin
                    if (last_bit) begin
                        state_nx = parity_ok ? FULL : ABORT;
                    end else begin
                        state_nx = RECV;
                    end
                end
            end
            RECV: begin
                if (clk_rise) begin
                    if (last_bit) begin
                        state_nx = parity_ok ? FULL : ABORT;
                    end
                end else if (timed_out) begin
                    state_nx = ABORT;
                end
            end
            FULL: begin
                readyForTransferOut = 1'b0;
                dataValid           = 1'b1;
                if (ackIn) begin
                    state_nx = IDLE;
                end
            end
            ABORT: begin
                frameErr = 1'b1;
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    assign ps = state;

    // sr is zero whenever a frame starts, so IDLE can shift the first bit in like any other.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr       <= '0;
            cnt      <= '0;
            tcnt     <= '0;
            dataWord <= '0;
        end else begin
            case (state)
                IDLE, RECV: begin
                    if (clk_rise || (state == IDLE)) begin
                        tcnt <= '0;
                    end else if (tcnt != TW'(TIMEOUT)) begin
                        tcnt <= tcnt + TW'(1);
                    end
                    if (clk_rise) begin
                        if (last_bit) begin
                            sr  <= '0;
                            cnt <= '0;
                            if (parity_ok) begin
                                dataWord <= word_cand;
                            end
                        end else begin
                            sr  <= sr_shift;
                            cnt <= cnt_inc;
                        end
                    end
                end
                ABORT: begin
                    sr   <= '0;
                    cnt  <= '0;
                    tcnt <= '0;
                end
                default: begin
                    tcnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scanner_receiver.sv
// Scoreboard bench for scanner_receiver: directed link scenarios plus random frames checked
// against a frame-level model of the receiver.
module tb_scanner_receiver;

    localparam int WIDTH   = 8;
    localparam int TIMEOUT = 16;

    logic             clk    = 1'b0;
    logic             rst    = 1'b0;
    logic             clkIn  = 1'b0;
    logic             dataIn = 1'b0;
    logic             ackIn  = 1'b0;
    logic             readyForTransferOut;
    logic [WIDTH-1:0] dataWord;
    logic             dataValid;
    logic             frameErr;
    logic [1:0]       ps;

    scanner_receiver #(.WIDTH(WIDTH), .TIMEOUT(TIMEOUT)) dut (
        .clk                 (clk),
        .rst                 (rst),
        .clkIn               (clkIn),
        .dataIn              (dataIn),
        .ackIn               (ackIn),
        .readyForTransferOut (readyForTransferOut),
        .dataWord            (dataWord),
        .dataValid           (dataValid),
        .frameErr            (frameErr),
        .ps                  (ps)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        logic [7:0] data;
        int         lat;
    } exp_t;

    exp_t        sb[$];
    int          n_checks  = 0;
    int          n_fail    = 0;
    int unsigned cyc       = 0;
    int unsigned last_rise = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic push_exp(input bit err, input logic [7:0] d, input int lat);
        exp_t e;
        e.is_err = err;
        e.data   = d;
        e.lat    = lat;
        sb.push_back(e);
    endtask

    // Entered and left on a negedge; rise of clkIn and its data bit change together.
    task automatic send_bit(input logic b, input int hi, input int lo);
        dataIn    = b;
        clkIn     = 1'b1;
        last_rise = cyc;
        repeat (hi) @(negedge clk);
        clkIn = 1'b0;
        repeat (lo) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] w, input bit flip, input int hi, input int lo);
        for (int i = WIDTH - 1; i >= 0; i--) send_bit(w[i], hi, lo);
`ifdef SCANNER_RX_PARITY_EN
        send_bit((^w) ^ flip, hi, lo);
`else
        if (flip) $display("note: parity flip requested without parity build");
`endif
    endtask

    // Frame-level model: a good frame sent while ready yields its word 3 cycles after the last
    // rise; a bad-parity frame yields an error at the same point.
    task automatic expect_frame(input logic [7:0] w, input bit flip);
        if (flip) push_exp(1'b1, 8'h00, 3);
        else      push_exp(1'b0, w, 3);
    endtask

    task automatic pulse_ack(input bit check_idle);
        ackIn = 1'b1;
        @(negedge clk);
        ackIn = 1'b0;
        if (check_idle) begin
            check("ack_valid_low", dataValid, 1'b0);
            check("ack_ps_idle", ps, 2'b00);
            check("ack_ready_high", readyForTransferOut, 1'b1);
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_ps"}, ps, 2'b00);
        check({tag, "_ready"}, readyForTransferOut, 1'b1);
        check({tag, "_valid"}, dataValid, 1'b0);
        check({tag, "_word"}, dataWord, 8'h00);
        check({tag, "_ferr"}, frameErr, 1'b0);
    endtask

    // Monitor: pops one expectation per presented word or error pulse.
    logic       mon_pv = 1'b0;
    logic       mon_pf = 1'b0;
    logic [7:0] mon_held = 8'h00;

    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            mon_pv = 1'b0;
            mon_pf = 1'b0;
        end else begin
            if (mon_pf) begin
                check("abort_then_idle_ps", ps, 2'b00);
                check("ferr_one_cycle", frameErr, 1'b0);
            end
            if (frameErr) begin
                check("abort_ps", ps, 2'b11);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_frame_err: got pulse, expected none (t=%0t)", $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_err", e.is_err, 1'b1);
                    check("err_latency", cyc - last_rise, e.lat);
                end
            end
            if (dataValid && !mon_pv) begin
                check("full_ps", ps, 2'b10);
                check("full_ready_low", readyForTransferOut, 1'b0);
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_word: got 0x%0h, expected none (t=%0t)", dataWord, $time);
                end else begin
                    e = sb.pop_front();
                    check("sb_kind_word", e.is_err, 1'b0);
                    check("sb_word", dataWord, e.data);
                    check("valid_latency", cyc - last_rise, e.lat);
                end
                mon_held = dataWord;
            end else if (dataValid) begin
                check("word_stable", dataWord, mon_held);
            end
            mon_pv = dataValid;
            mon_pf = frameErr;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got no finish, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] w;
        bit         flip;
        int         hi;
        int         lo;

        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_reset("por");
        rst = 1'b1;
        @(negedge clk);

        // Basic word and handshake
        expect_frame(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b0, 4, 4);
        repeat (2) @(negedge clk);
        check("a5_valid", dataValid, 1'b1);
        check("a5_word", dataWord, 8'hA5);
        check("a5_ps", ps, 2'b10);
        check("a5_ready", readyForTransferOut, 1'b0);
        pulse_ack(1'b1);
        repeat (2) @(negedge clk);

        // Async reset while FULL
        expect_frame(8'h5A, 1'b0);
        send_frame(8'h5A, 1'b0, 3, 3);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 check_reset("rst_full");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);

        // Back-pressure: a whole frame while FULL is dropped
        expect_frame(8'h3C, 1'b0);
        send_frame(8'h3C, 1'b0, 4, 4);
        send_frame(8'h81, 1'b0, 3, 3);
        repeat (6) @(negedge clk);
        check("bp_word_held", dataWord, 8'h3C);
        check("bp_valid_held", dataValid, 1'b1);
        pulse_ack(1'b1);
        expect_frame(8'hC3, 1'b0);
        send_frame(8'hC3, 1'b0, 4, 4);
        repeat (2) @(negedge clk);
        pulse_ack(1'b1);

        // Serial clock period of exactly TIMEOUT cycles must not abort
        expect_frame(8'h96, 1'b0);
        send_frame(8'h96, 1'b0, TIMEOUT / 2, TIMEOUT / 2);
        repeat (2) @(negedge clk);
        pulse_ack(1'b1);

        // Timeout after 5 bits, then a clean word
        push_exp(1'b1, 8'h00, 3 + TIMEOUT);
        for (int i = 0; i < 5; i++) send_bit(i[0], 4, 4);
        repeat (30) @(negedge clk);
        check("to_valid_low", dataValid, 1'b0);
        expect_frame(8'h0F, 1'b0);
        send_frame(8'h0F, 1'b0, 4, 4);
        repeat (2) @(negedge clk);
        pulse_ack(1'b1);

        // Reset mid-word discards partial bits
        for (int i = 0; i < 4; i++) send_bit(1'b0, 3, 3);
        #2 rst = 1'b0;
        #1 check_reset("rst_mid");
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        expect_frame(8'hFF, 1'b0);
        send_frame(8'hFF, 1'b0, 3, 3);
        repeat (2) @(negedge clk);
        pulse_ack(1'b1);

`ifdef SCANNER_RX_PARITY_EN
        expect_frame(8'hA5, 1'b0);
        send_frame(8'hA5, 1'b0, 4, 4);
        repeat (2) @(negedge clk);
        pulse_ack(1'b1);
        expect_frame(8'hA5, 1'b1);
        send_frame(8'hA5, 1'b1, 4, 4);
        repeat (4) @(negedge clk);
        check("par_bad_valid_low", dataValid, 1'b0);
`endif

        // Random frames, random serial timing and ack delay
        for (int n = 0; n < 40; n++) begin
            w  = 8'($urandom);
            hi = int'($urandom_range(2, 6));
            lo = int'($urandom_range(2, 6));
`ifdef SCANNER_RX_PARITY_EN
            flip = ($urandom_range(0, 3) == 0);
`else
            flip = 1'b0;
`endif
            expect_frame(w, flip);
            send_frame(w, flip, hi, lo);
            repeat (int'($urandom_range(1, 5))) @(negedge clk);
            pulse_ack(1'b0);
            repeat (2) @(negedge clk);
        end

        repeat (10) @(negedge clk);
        check("sb_drained", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
